// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types and widths for the AES request scheduler.
package aes_sched_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int SCHED_NUM_REQ = 4;
  localparam int ID_W = $clog2(SCHED_NUM_REQ);
  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [AES_BLOCK_W-1:0] data;
  } rsp_entry_t;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/aes_sched_fifo.sv
// aes_sched_fifo: synchronous show-ahead FIFO with occupancy count.
module aes_sched_fifo #(
  parameter int DEPTH = 16,
  parameter type T = logic,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o
);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop  = pop_i && cnt_q != '0;
    do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
    wr_d    = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d    = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  // Credit admission guarantees a slot for every returning block.
  always @(posedge clk) begin
    if (!rst) assert (!(push_i && !do_push)) else $error("aes_sched_fifo overflow");
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler: round-robin sharing of a pipelined AES core with credit-based response queueing.
// Define AES_SCHED_STATS_EN to add per-requester grant counters and a stall counter.
module aes_req_scheduler import aes_sched_pkg::*; #(
  parameter int NUM_REQ = SCHED_NUM_REQ,
  parameter int LATENCY = 10,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                aes_valid_o,
  output logic [AES_BLOCK_W-1:0]              aes_plaintext_o,
  input  logic                                aes_valid_i,
  input  logic [AES_BLOCK_W-1:0]              aes_ciphertext_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [AES_BLOCK_W-1:0]              rsp_data_o,
  output logic [ID_W-1:0]                     rsp_id_o,
  output logic                                busy_o,
  output logic                                error_o
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]            stat_grant_o,
  output logic [31:0]                         stat_stall_o
`endif
);
  logic [CW-1:0] credit_q, credit_d, fifo_cnt;
  logic [ID_W-1:0] rr_q, rr_d, gnt_id, aes_id_q, aes_id_d;
  logic [AES_BLOCK_W-1:0] pt_q, pt_d;
  logic gnt_valid, can_issue, aes_valid_q, error_q, error_d, pop;
  tag_t tag_q [LATENCY];
  tag_t tag_d [LATENCY];
  rsp_entry_t fifo_in, fifo_out;
  assign can_issue = !rst && credit_q < CW'(FIFO_DEPTH);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (can_issue && !gnt_valid && req_valid_i[(int'(rr_q) + i) % NUM_REQ]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'((int'(rr_q) + i) % NUM_REQ);
      end
  end
  always_comb begin
    rr_d     = gnt_valid ? (int'(gnt_id) == NUM_REQ - 1 ? '0 : gnt_id + ID_W'(1)) : rr_q;
    aes_id_d = gnt_id;
    pt_d     = gnt_valid ? req_data_i[gnt_id] : pt_q;
    pop      = rsp_valid_o && rsp_ready_i;
    credit_d = credit_q + CW'(gnt_valid) - CW'(pop);
    error_d  = error_q || (tag_q[LATENCY-1].valid != aes_valid_i);
    // Idle slots carry id 0 so a stray core result is tagged deterministically.
    tag_d[0] = aes_valid_q ? tag_t'{valid: 1'b1, id: aes_id_q} : '0;
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      credit_q    <= '0;
      aes_valid_q <= 1'b0;
      aes_id_q    <= '0;
      pt_q        <= '0;
      error_q     <= 1'b0;
      tag_q       <= '{default: '0};
    end else begin
      rr_q        <= rr_d;
      credit_q    <= credit_d;
      aes_valid_q <= gnt_valid;
      aes_id_q    <= aes_id_d;
      pt_q        <= pt_d;
      error_q     <= error_d;
      tag_q       <= tag_d;
    end
  end
  assign fifo_in = '{id: tag_q[LATENCY-1].id, data: aes_ciphertext_i};
  aes_sched_fifo #(.DEPTH(FIFO_DEPTH), .T(rsp_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aes_valid_i),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .count_o (fifo_cnt)
  );
  assign req_ready_o     = gnt_valid ? NUM_REQ'(1) << gnt_id : '0;
  assign aes_valid_o     = aes_valid_q;
  assign aes_plaintext_o = pt_q;
  assign rsp_valid_o     = fifo_cnt != '0;
  assign rsp_data_o      = rsp_valid_o ? fifo_out.data : '0;
  assign rsp_id_o        = rsp_valid_o ? fifo_out.id : '0;
  assign busy_o          = credit_q != '0;
  assign error_o         = error_q;
`ifdef AES_SCHED_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] stall_q, stall_d;
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (gnt_valid) grant_cnt_d[gnt_id] = grant_cnt_q[gnt_id] + 32'd1;
    stall_d = (|req_valid_i && !can_issue && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_q     <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_q     <= stall_d;
    end
  end
  assign stat_grant_o = grant_cnt_q;
  assign stat_stall_o = stall_q;
`endif
endmodule
